control_sequencer: RTL

- Hardwired Moore control unit for the single-bus CPU datapath.
- Steps every instruction through fetch (T0-T2) and execute (T3-T7).
- Drives all bus-source, register-load, select-and-encode, RAM and ALU-opcode strobes from the current step and the IR contents.
- Supports halt/stop for run control.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/control_decode.sv | 104 ++++++++++
 rtl/control_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the single-bus CPU control unit: step encoding,
// opcode and ALU codes, strobe bundle and opcode classification.
package ctrl_pkg;

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} step_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010,
                         OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101,
                         OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHL  = 5'b01000,
                         OP_ROR  = 5'b01001, OP_ROL  = 5'b01010, OP_ADDI = 5'b01011,
                         OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_MUL  = 5'b01110,
                         OP_DIV  = 5'b01111, OP_NEG  = 5'b10000, OP_NOT  = 5'b10001,
                         OP_BR   = 5'b10010, OP_JR   = 5'b10011, OP_IN   = 5'b10101,
                         OP_OUT  = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000,
                         OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  localparam logic [4:0] ALU_ADD = 5'b00011, ALU_AND = 5'b00101, ALU_OR = 5'b00110;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
  } op_class_t;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, inc_pc;
    logic gra, grb, grc, rin, rout, ba_out;
    logic read, ram_read, ram_write;
  } strobes_t;

  // Unlisted opcodes fall into C_NOP so they retire at T2.
  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI: return C_IMM;
      OP_LDI:                   return C_LDI;
      OP_LD:                    return C_LD;
      OP_ST:                    return C_ST;
      OP_MUL, OP_DIV:           return C_MULDIV;
      OP_NEG, OP_NOT:           return C_UNARY;
      OP_BR:                    return C_BR;
      OP_JR:                    return C_JR;
      OP_IN:                    return C_IN;
      OP_OUT:                   return C_OUT;
      OP_MFHI:                  return C_MFHI;
      OP_MFLO:                  return C_MFLO;
      OP_HALT:                  return C_HALT;
      default:                  return C_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decoder: {step, opcode, br_flag} -> strobe bundle,
// ALU opcode and a flag marking the final step of the instruction.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  step_t            step,
  input  logic [OPW-1:0]   opcode,
  input  logic             br_flag,
  output strobes_t         strb,
  output logic [OPW-1:0]   alu_op,
  output logic             last_step
);

  op_class_t cls;
  assign cls = classify(opcode);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    strb      = '0;
    alu_op    = ALU_ADD;
    last_step = 1'b0;
    case (step)
      T0: begin strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; strb.z_in = 1'b1; end
      T1: begin
        strb.zlow_out = 1'b1; strb.pc_in = 1'b1; strb.ram_read = 1'b1;
        strb.read = 1'b1; strb.mdr_in = 1'b1;
      end
      T2: begin strb.mdr_out = 1'b1; strb.ir_in = 1'b1; last_step = (cls == C_NOP); end
      HALT: ;
      default: begin
        case (cls)
          C_ALU, C_IMM, C_LDI, C_LD, C_ST: begin
            case (step)
              T3: begin
                strb.grb = 1'b1; strb.rout = 1'b1; strb.y_in = 1'b1;
                strb.ba_out = (cls == C_LDI) || (cls == C_LD) || (cls == C_ST);
              end
              T4: begin
                strb.z_in = 1'b1;
                if (cls == C_ALU) begin
                  strb.grc = 1'b1; strb.rout = 1'b1; alu_op = opcode;
                end else begin
                  strb.c_out = 1'b1;
                  if (opcode == OP_ANDI) alu_op = ALU_AND;
                  else if (opcode == OP_ORI) alu_op = ALU_OR;
                end
              end
              T5: begin
                strb.zlow_out = 1'b1;
                if ((cls == C_LD) || (cls == C_ST)) strb.mar_in = 1'b1;
                else begin strb.gra = 1'b1; strb.rin = 1'b1; last_step = 1'b1; end
              end
              T6: begin
                strb.mdr_in = 1'b1;
                if (cls == C_LD) begin strb.ram_read = 1'b1; strb.read = 1'b1; end
                else begin strb.gra = 1'b1; strb.rout = 1'b1; end
              end
              default: begin
                last_step = 1'b1;
                if (cls == C_LD) begin strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; end
                else strb.ram_write = 1'b1;
              end
            endcase
          end
          C_MULDIV: begin
            case (step)
              T3: begin strb.gra = 1'b1; strb.rout = 1'b1; strb.y_in = 1'b1; end
              T4: begin strb.grb = 1'b1; strb.rout = 1'b1; strb.z_in = 1'b1; alu_op = opcode; end
              T5: begin strb.zlow_out = 1'b1; strb.lo_in = 1'b1; end
              default: begin strb.zhigh_out = 1'b1; strb.hi_in = 1'b1; last_step = 1'b1; end
            endcase
          end
          C_UNARY: begin
            if (step == T3) begin
              strb.grb = 1'b1; strb.rout = 1'b1; strb.z_in = 1'b1; alu_op = opcode;
            end else begin
              strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; last_step = 1'b1;
            end
          end
          C_BR: begin
            // PC already holds PC+1, so T4/T5 form PC+1+C in Z.
            case (step)
              T3: begin strb.gra = 1'b1; strb.rout = 1'b1; strb.con_in = 1'b1; end
              T4: begin strb.pc_out = 1'b1; strb.y_in = 1'b1; end
              T5: begin strb.c_out = 1'b1; strb.z_in = 1'b1; end
              default: begin
                strb.zlow_out = br_flag; strb.pc_in = br_flag; last_step = 1'b1;
              end
            endcase
          end
          C_JR:   begin strb.gra = 1'b1; strb.rout = 1'b1; strb.pc_in = 1'b1; last_step = 1'b1; end
          C_IN:   begin strb.inport_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; last_step = 1'b1; end
          C_OUT:  begin strb.gra = 1'b1; strb.rout = 1'b1; strb.outport_in = 1'b1; last_step = 1'b1; end
          C_MFHI: begin strb.hi_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; last_step = 1'b1; end
          C_MFLO: begin strb.lo_out = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1; last_step = 1'b1; end
          default: last_step = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: step register, run/halt control and
// expansion of the decoded strobe bundle onto the datapath control pins.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    ir,
  input  logic           br_flag,
  input  logic           stop,
  output logic           run,
  output logic           PCout, Zlowout, Zhighout, MDRout, HIout, LOout, INPORTout, Cout,
  output logic           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin, IncPC,
  output logic           GRA, GRB, GRC, Rin_logic, Rout_logic, BA_out,
  output logic           Read, RAM_read, RAM_write,
  output logic [OPW-1:0] alu_op
);

  step_t          step, next_step;
  strobes_t       dec_strb, strb;
  logic [OPW-1:0] opcode, dec_alu;
  logic           last_step, halt_op, unused_ir_bits;

  assign opcode         = ir[31:32-OPW];
  assign unused_ir_bits = ^ir[31-OPW:0];
  assign halt_op        = (classify(opcode) == C_HALT);

  control_decode #(.OPW(OPW)) u_decode (
    .step      (step),
    .opcode    (opcode),
    .br_flag   (br_flag),
    .strb      (dec_strb),
    .alu_op    (dec_alu),
    .last_step (last_step)
  );

  always_comb begin
    next_step = step;
    if (step != HALT) begin
      if (last_step) next_step = (stop || halt_op) ? HALT : T0;
      else           next_step = step_t'(step + 4'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (clr) step <= T0;
    else     step <= next_step;
  end

  // clr silences the outputs immediately so an abandoned instruction writes nothing.
  assign strb   = (clr || step == HALT) ? '0 : dec_strb;
  assign alu_op = (clr || step == HALT) ? '0 : dec_alu;
  assign run    = (step != HALT);

  assign PCout      = strb.pc_out;
  assign Zlowout    = strb.zlow_out;
  assign Zhighout   = strb.zhigh_out;
  assign MDRout     = strb.mdr_out;
  assign HIout      = strb.hi_out;
  assign LOout      = strb.lo_out;
  assign INPORTout  = strb.inport_out;
  assign Cout       = strb.c_out;
  assign PCin       = strb.pc_in;
  assign IRin       = strb.ir_in;
  assign MARin      = strb.mar_in;
  assign MDRin      = strb.mdr_in;
  assign Yin        = strb.y_in;
  assign Zin        = strb.z_in;
  assign HIin       = strb.hi_in;
  assign LOin       = strb.lo_in;
  assign CONin      = strb.con_in;
  assign OUTPORTin  = strb.outport_in;
  assign IncPC      = strb.inc_pc;
  assign GRA        = strb.gra;
  assign GRB        = strb.grb;
  assign GRC        = strb.grc;
  assign Rin_logic  = strb.rin;
  assign Rout_logic = strb.rout;
  assign BA_out     = strb.ba_out;
  assign Read       = strb.read;
  assign RAM_read   = strb.ram_read;
  assign RAM_write  = strb.ram_write;

endmodule
